// File: rtl/ttio_icb_arbt_if.sv
// rtl/ttio_icb_arbt_if.sv - ICB command/response bundle shared by the arbiter ports
//
// Purpose: one ICB link, command channel (valid/ready plus payload) and
// response channel (valid/ready plus err/rdata).
// Ports (signals):
//   cmd_valid/cmd_ready  command handshake
//   cmd_addr             ADDR_W address
//   cmd_read             1=read, 0=write
//   cmd_wdata/cmd_wmask  write data and byte mask
//   cmd_lock             keep the bus for this issuer after this command
//   rsp_valid/rsp_ready  response handshake
//   rsp_err/rsp_rdata    bus error and read data
// Modports: master issues commands and takes responses; slave is the
// opposite side.
interface ttio_icb_arbt_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_read;
  logic [XLEN-1:0]   cmd_wdata;
  logic [XLEN/8-1:0] cmd_wmask;
  logic              cmd_lock;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_err;
  logic [XLEN-1:0]   rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_lock,
    input  cmd_ready,
    input  rsp_valid, rsp_err, rsp_rdata,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_lock,
    output cmd_ready,
    output rsp_valid, rsp_err, rsp_rdata,
    input  rsp_ready
  );
endinterface

// File: rtl/ttio_icb_arbt.sv
// rtl/ttio_icb_arbt.sv - two-requester ICB arbiter with lock and in-order response routing
//
// Purpose: shares one downstream ICB port between the TTIO unit (i0) and
// the LSU/AGU path (i1). Commands are granted combinationally, lock
// sequences keep the bus on one requester, and an in-order ID FIFO steers
// each response back to the requester that issued the command.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   i0         slave ICB link from TTIO (requester 0)
//   i1         slave ICB link from LSU/AGU (requester 1)
//   o          master ICB link to memory
//   arbt_idle  no outstanding transaction and no lock held
// Configuration macro: TTIO_ARBT_RR_EN selects round-robin arbitration
// (a 1-bit preferred-requester pointer); undefined gives fixed priority
// with requester 0 first.
module ttio_icb_arbt #(
  parameter int ADDR_W     = 32,
  parameter int XLEN       = 32,
  parameter int OUTS_DEPTH = 4,
  parameter int OUTS_PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  ttio_icb_arbt_if.slave   i0,
  ttio_icb_arbt_if.slave   i1,
  ttio_icb_arbt_if.master  o,
  output logic             arbt_idle
);

  localparam logic [OUTS_PTR_W-1:0] PTR_ONE = 1;
  localparam logic [OUTS_PTR_W:0]   CNT_ONE = 1;
  localparam logic [OUTS_PTR_W:0]   CNT_FULL = (OUTS_PTR_W+1)'(OUTS_DEPTH);

  logic                  fifo_q [OUTS_DEPTH];
  logic                  fifo_d [OUTS_DEPTH];
  logic [OUTS_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OUTS_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OUTS_PTR_W:0]   cnt_q, cnt_d;
  logic                  lock_vld_q, lock_vld_d;
  logic                  lock_id_q, lock_id_d;
`ifdef TTIO_ARBT_RR_EN
  logic                  rr_q, rr_d;
`endif

  logic gnt;
  logic req;
  logic full;
  logic empty;
  logic head;
  logic cmd_hs;
  logic rsp_hs;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Grant selection. A held lock pins the grant to its owner; otherwise a
  // contested cycle goes to the preferred requester.
  always_comb begin
    gnt = 1'b0;
    req = 1'b0;
    if (lock_vld_q) begin
      gnt = lock_id_q;
      req = lock_id_q ? i1.cmd_valid : i0.cmd_valid;
    end else if (i0.cmd_valid && i1.cmd_valid) begin
`ifdef TTIO_ARBT_RR_EN
      gnt = rr_q;
`else
      gnt = 1'b0;
`endif
      req = 1'b1;
    end else begin
      gnt = i1.cmd_valid;
      req = i0.cmd_valid | i1.cmd_valid;
    end
  end

  // Command forwarding. A full FIFO blocks the downstream command outright;
  // a pop in the same cycle does not open the slot early.
  assign o.cmd_valid = req && !full && !rst;
  assign o.cmd_addr  = gnt ? i1.cmd_addr  : i0.cmd_addr;
  assign o.cmd_read  = gnt ? i1.cmd_read  : i0.cmd_read;
  assign o.cmd_wdata = gnt ? i1.cmd_wdata : i0.cmd_wdata;
  assign o.cmd_wmask = gnt ? i1.cmd_wmask : i0.cmd_wmask;
  assign o.cmd_lock  = gnt ? i1.cmd_lock  : i0.cmd_lock;

  assign i0.cmd_ready = o.cmd_valid && o.cmd_ready && !gnt;
  assign i1.cmd_ready = o.cmd_valid && o.cmd_ready &&  gnt;
  assign cmd_hs       = o.cmd_valid && o.cmd_ready;

  // Response routing by FIFO head. An empty FIFO never accepts a response,
  // so a stray downstream response is left stalled rather than misrouted.
  assign i0.rsp_valid = o.rsp_valid && !empty && !rst && !head;
  assign i1.rsp_valid = o.rsp_valid && !empty && !rst &&  head;
  assign o.rsp_ready  = !empty && !rst && (head ? i1.rsp_ready : i0.rsp_ready);
  assign i0.rsp_err   = o.rsp_err;
  assign i1.rsp_err   = o.rsp_err;
  assign i0.rsp_rdata = o.rsp_rdata;
  assign i1.rsp_rdata = o.rsp_rdata;
  assign rsp_hs       = o.rsp_valid && o.rsp_ready;

  assign arbt_idle = rst || (empty && !lock_vld_q);

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
`ifdef TTIO_ARBT_RR_EN
    rr_d       = rr_q;
`endif

    if (cmd_hs) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
      // Only the lock owner can handshake while locked, so the granted
      // command's lock bit alone decides whether the lock is held next.
      lock_vld_d       = o.cmd_lock;
      lock_id_d        = gnt;
`ifdef TTIO_ARBT_RR_EN
      if (!lock_vld_q) begin
        rr_d = ~gnt;
      end
`endif
    end

    if (rsp_hs) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({cmd_hs, rsp_hs})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q     <= '{default: 1'b0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
`ifdef TTIO_ARBT_RR_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
`ifdef TTIO_ARBT_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

endmodule
